// File: rtl/calc_controller_param.sv
// calc_controller_param: two-operand entry sequencer with 4-op signed saturating ALU and optional chain mode
//   clk, reset               : system clock, synchronous active-high reset
//   confirm                  : debounced level, rising edge advances the entry FSM
//   display_mode_change      : debounced level, rising edge toggles display_mode
//   operator_select[1:0]     : 00 add, 01 sub (A-B), 10 mul, 11 max(A,B); sampled in S_CALC
//   operand_input[OPERAND_W] : unsigned switch value, zero-extended to RESULT_W
//   state[2:0]               : current FSM encoding
//   display_value[RESULT_W]  : signed value for the 7-seg driver
//   display_mode             : 0 decimal, 1 hex
//   result_valid             : high while a result is held
//   overflow                 : held result was clamped
module calc_controller_param #(
    parameter int OPERAND_W = 4,
    parameter int RESULT_W  = 8,
    parameter bit CHAIN_EN  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 confirm,
    input  logic                 display_mode_change,
    input  logic [1:0]           operator_select,
    input  logic [OPERAND_W-1:0] operand_input,
    output logic [2:0]           state,
    output logic [RESULT_W-1:0]  display_value,
    output logic                 display_mode,
    output logic                 result_valid,
    output logic                 overflow
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_ENTER_A = 3'b001,
        S_ENTER_B = 3'b011,
        S_CALC    = 3'b100,
        S_RESULT  = 3'b101
    } state_t;

    localparam logic signed [2*RESULT_W-1:0] sat_max = (2*RESULT_W)'((64'sd1 <<< (RESULT_W-1)) - 64'sd1);
    localparam logic signed [2*RESULT_W-1:0] sat_min = -sat_max - 1;

    state_t state_q, state_d;
    logic confirm_q, mode_q, conf_pe, mode_pe;
    logic signed [RESULT_W-1:0] a_q, b_q, result_q, operand_z, result_sat;
    logic signed [2*RESULT_W-1:0] a_w, b_w, full;
    logic sat, load_a, load_b, load_r, chain_a, clr_ov;

    assign conf_pe   = confirm & ~confirm_q;
    assign mode_pe   = display_mode_change & ~mode_q;
    assign operand_z = {{(RESULT_W-OPERAND_W){1'b0}}, operand_input};
    assign a_w       = {{RESULT_W{a_q[RESULT_W-1]}}, a_q};
    assign b_w       = {{RESULT_W{b_q[RESULT_W-1]}}, b_q};
    assign state     = state_q;

    // Compute at double width so no operation can wrap before clamping
    always_comb begin
        full = operator_select == 2'b00 ? a_w + b_w :
               operator_select == 2'b01 ? a_w - b_w :
               operator_select == 2'b10 ? a_w * b_w :
               (a_w > b_w ? a_w : b_w);
        sat        = (full > sat_max) || (full < sat_min);
        result_sat = full > sat_max ? sat_max[RESULT_W-1:0] :
                     full < sat_min ? sat_min[RESULT_W-1:0] : full[RESULT_W-1:0];
    end

    always_comb begin
        state_d       = state_q;
        display_value = '0;
        result_valid  = 1'b0;
        load_a        = 1'b0;
        load_b        = 1'b0;
        load_r        = 1'b0;
        chain_a       = 1'b0;
        clr_ov        = 1'b0;
        case (state_q)
            S_IDLE: state_d = conf_pe ? S_ENTER_A : S_IDLE;
            S_ENTER_A: begin
                display_value = operand_z;
                load_a        = conf_pe;
                state_d       = conf_pe ? S_ENTER_B : S_ENTER_A;
            end
            S_ENTER_B: begin
                display_value = operand_z;
                load_b        = conf_pe;
                state_d       = conf_pe ? S_CALC : S_ENTER_B;
            end
            S_CALC: begin
                load_r  = 1'b1;
                state_d = S_RESULT;
            end
            S_RESULT: begin
                display_value = result_q;
                result_valid  = 1'b1;
                clr_ov        = conf_pe;
                chain_a       = conf_pe & CHAIN_EN;
                state_d       = !conf_pe ? S_RESULT : CHAIN_EN ? S_ENTER_B : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge detectors load the live inputs in reset so a held button gives no edge on release of reset
        confirm_q <= confirm;
        mode_q    <= display_mode_change;
        if (reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            overflow     <= 1'b0;
            display_mode <= 1'b0;
        end else begin
            state_q <= state_d;
            if (mode_pe) display_mode <= ~display_mode;
            if (load_a) a_q <= operand_z;
            else if (chain_a) a_q <= result_q;
            if (load_b) b_q <= operand_z;
            if (load_r) begin
                result_q <= result_sat;
                overflow <= sat;
            end else if (clr_ov) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_calc_controller_param.sv
// tb_calc_controller_param: table, directed and random checks of calc_controller_param (plain and chain variants)
module tb_calc_controller_param;
    logic clk = 1'b0;
    logic reset[2];
    logic confirm[2];
    logic mchg[2];
    logic [1:0] op[2];
    logic [3:0] opnd[2];
    logic [2:0] st[2];
    logic [7:0] dv[2];
    logic mode[2], rv[2], ovf[2];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    calc_controller_param #(.OPERAND_W(4), .RESULT_W(8), .CHAIN_EN(0)) dut (
        .clk(clk), .reset(reset[0]), .confirm(confirm[0]), .display_mode_change(mchg[0]),
        .operator_select(op[0]), .operand_input(opnd[0]), .state(st[0]), .display_value(dv[0]),
        .display_mode(mode[0]), .result_valid(rv[0]), .overflow(ovf[0]));

    calc_controller_param #(.OPERAND_W(4), .RESULT_W(8), .CHAIN_EN(1)) dut_c (
        .clk(clk), .reset(reset[1]), .confirm(confirm[1]), .display_mode_change(mchg[1]),
        .operator_select(op[1]), .operand_input(opnd[1]), .state(st[1]), .display_value(dv[1]),
        .display_mode(mode[1]), .result_valid(rv[1]), .overflow(ovf[1]));

    typedef struct {
        int a;
        int b;
        logic [1:0] o;
        int ev;
        int eo;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input int d);
        confirm[d] = 1'b1;
        tick();
        confirm[d] = 1'b0;
        tick();
    endtask

    // From S_IDLE: enter operand A and leave the FSM in S_ENTER_B
    task automatic enter_a(input int d, input int a);
        press(d);
        chk("enter_a_state", int'(st[d]), 1);
        opnd[d] = 4'(a);
        #1;
        chk("enter_a_live", int'($signed(dv[d])), a);
        press(d);
        chk("enter_b_state", int'(st[d]), 3);
    endtask

    // In S_ENTER_B: confirm B, check the two-cycle latency and the held result
    task automatic do_b(input int d, input int b, input logic [1:0] o, input int ev, input int eo);
        opnd[d] = 4'(b);
        op[d] = o;
        confirm[d] = 1'b1;
        tick();
        chk("calc_state", int'(st[d]), 4);
        chk("calc_rv", int'(rv[d]), 0);
        confirm[d] = 1'b0;
        tick();
        chk("result_state", int'(st[d]), 5);
        chk("result_rv", int'(rv[d]), 1);
        chk("result_val", int'($signed(dv[d])), ev);
        chk("result_ovf", int'(ovf[d]), eo);
    endtask

    function automatic int model(input int a, input int b, input logic [1:0] o, output int ov);
        int r;
        r = o == 2'd0 ? a + b : o == 2'd1 ? a - b : o == 2'd2 ? a * b : (a > b ? a : b);
        ov = (r > 127 || r < -128) ? 1 : 0;
        return r > 127 ? 127 : r < -128 ? -128 : r;
    endfunction

    initial begin
        vec_t vt[10];
        int acc, ev, eo, a, b;
        logic [1:0] o;
        vt[0] = '{5, 3, 2'd0, 8, 0};
        vt[1] = '{2, 9, 2'd1, -7, 0};
        vt[2] = '{2, 9, 2'd3, 9, 0};
        vt[3] = '{15, 15, 2'd2, 127, 1};
        vt[4] = '{0, 15, 2'd1, -15, 0};
        vt[5] = '{15, 0, 2'd0, 15, 0};
        vt[6] = '{9, 2, 2'd3, 9, 0};
        vt[7] = '{12, 11, 2'd2, 127, 1};
        vt[8] = '{0, 0, 2'd2, 0, 0};
        vt[9] = '{7, 7, 2'd1, 0, 0};
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            confirm[d] = 1'b0;
            mchg[d] = 1'b0;
            op[d] = 2'd0;
            opnd[d] = 4'd9;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_state", int'(st[d]), 0);
            chk("rst_dv", int'(dv[d]), 0);
            chk("rst_mode", int'(mode[d]), 0);
            chk("rst_rv", int'(rv[d]), 0);
            chk("rst_ovf", int'(ovf[d]), 0);
            reset[d] = 1'b0;
        end
        tick();
        chk("idle_dv", int'(dv[0]), 0);

        for (int i = 0; i < 10; i++) begin
            enter_a(0, vt[i].a);
            do_b(0, vt[i].b, vt[i].o, vt[i].ev, vt[i].eo);
            op[0] = ~vt[i].o;
            tick();
            chk("held_after_op_change", int'($signed(dv[0])), vt[i].ev);
            press(0);
            chk("back_idle", int'(st[0]), 0);
            chk("ovf_cleared", int'(ovf[0]), 0);
            chk("idle_rv", int'(rv[0]), 0);
        end

        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            o = 2'($urandom_range(0, 3));
            ev = model(a, b, o, eo);
            enter_a(0, a);
            do_b(0, b, o, ev, eo);
            press(0);
            chk("rnd_idle", int'(st[0]), 0);
        end

        enter_a(1, 5);
        do_b(1, 3, 2'd0, 8, 0);
        press(1);
        chk("chain_state", int'(st[1]), 3);
        do_b(1, 7, 2'd0, 15, 0);
        acc = 15;
        for (int i = 0; i < 3; i++) begin
            press(1);
            acc = acc - 15;
            do_b(1, 15, 2'd1, acc, 0);
        end
        chk("chain_m30", acc, -30);
        for (int i = 0; i < 25; i++) begin
            press(1);
            chk("chain_ovf_clr", int'(ovf[1]), 0);
            b = int'($urandom_range(0, 15));
            o = 2'($urandom_range(0, 3));
            ev = model(acc, b, o, eo);
            do_b(1, b, o, ev, eo);
            acc = ev;
        end

        enter_a(0, 6);
        confirm[0] = 1'b1;
        reset[0] = 1'b1;
        tick();
        chk("rst_mid_state", int'(st[0]), 0);
        chk("rst_mid_dv", int'(dv[0]), 0);
        reset[0] = 1'b0;
        repeat (3) tick();
        chk("held_through_rst", int'(st[0]), 0);
        confirm[0] = 1'b0;
        tick();
        chk("released", int'(st[0]), 0);
        press(0);
        chk("press_after_rst", int'(st[0]), 1);
        opnd[0] = 4'd15;
        press(0);
        opnd[0] = 4'd15;
        op[0] = 2'd2;
        confirm[0] = 1'b1;
        tick();
        chk("calc_before_rst", int'(st[0]), 4);
        confirm[0] = 1'b0;
        reset[0] = 1'b1;
        tick();
        chk("rst_calc_state", int'(st[0]), 0);
        chk("rst_calc_ovf", int'(ovf[0]), 0);
        chk("rst_calc_rv", int'(rv[0]), 0);
        reset[0] = 1'b0;
        tick();

        confirm[0] = 1'b1;
        mchg[0] = 1'b1;
        tick();
        chk("simul_state", int'(st[0]), 1);
        chk("simul_mode", int'(mode[0]), 1);
        mchg[0] = 1'b0;
        repeat (49) tick();
        chk("held50_state", int'(st[0]), 1);
        confirm[0] = 1'b0;
        tick();
        chk("held50_release", int'(st[0]), 1);
        mchg[0] = 1'b1;
        tick();
        chk("mode_pulse2", int'(mode[0]), 0);
        tick();
        chk("mode_held", int'(mode[0]), 0);
        mchg[0] = 1'b0;
        tick();
        mchg[0] = 1'b1;
        tick();
        chk("mode_pulse3", int'(mode[0]), 1);
        mchg[0] = 1'b0;
        tick();
        press(0);
        chk("mode_kept_fsm", int'(mode[0]), 1);
        chk("fsm_after_mode", int'(st[0]), 3);
        mchg[0] = 1'b1;
        tick();
        chk("mode_pulse4", int'(mode[0]), 0);
        mchg[0] = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
